// File: rtl/hk_pkg.sv
// Shared constants and types for the knight motion engine: USB HID keycodes,
// the motion state encoding and the screen geometry.
package hk_pkg;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } motion_state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA vsync into the Clk domain and turns each rising edge into a
// single-cycle registered tick. The tick is registered so the motion state
// updates a fixed three Clk edges after frame_clk is first sampled high.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic async_in,
    output logic tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_tick;

    // Two-flop synchroniser, one delay flop for edge detect, registered tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_tick  <= r_sync2 & ~r_sync3;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/knight_motion.sv
// Per-frame motion engine for the player knight: horizontal walking with
// screen-edge clamping and a ground/rise/fall jump state machine, all
// advanced once per synchronised video-frame tick.
module knight_motion
    import hk_pkg::*;
#(
    parameter int X_START  = 320,
    parameter int Y_GROUND = 400,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = SCREEN_W - 1,
    parameter int Y_MIN    = 0,
    parameter int SIZE_X   = 32,
    parameter int SIZE_Y   = 48,
    parameter int STEP_X   = 2,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] KnightX,
    output logic [9:0] KnightY,
    output logic [9:0] Knight_sizeX,
    output logic [9:0] Knight_sizeY,
    output logic       facing_left,
    output logic       airborne
);

    // Signed 11-bit bounds so comparisons against sums that may go negative
    // behave correctly at the left and top screen edges.
    localparam logic signed [10:0] X_LO_S     = 11'(X_MIN + SIZE_X / 2);
    localparam logic signed [10:0] X_HI_S     = 11'(X_MAX - SIZE_X / 2);
    localparam logic signed [10:0] Y_TOP_S    = 11'(Y_MIN + SIZE_Y / 2);
    localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
    localparam logic signed [5:0]  VEL_TAKEOFF = 6'(-JUMP_V);
    localparam logic signed [5:0]  VEL_GRAV    = 6'(GRAVITY);
    localparam logic signed [5:0]  VEL_MAX     = 6'(MAX_FALL);

    logic w_tick;

    frame_tick_sync u_tick (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .async_in (frame_clk),
        .tick     (w_tick)
    );

    logic [9:0]          r_x;
    logic [9:0]          r_y;
    logic signed [5:0]   r_vel;
    motion_state_t       r_state;
    logic                r_facing;
    logic                r_armed;

    logic [9:0]          w_x_next;
    logic [9:0]          w_y_next;
    logic signed [5:0]   w_vel_next;
    motion_state_t       w_state_next;
    logic                w_facing_next;
    logic                w_armed_next;

    logic                w_key_a;
    logic                w_key_d;
    logic                w_jump;
    logic signed [10:0]  w_x_sum;
    logic signed [10:0]  w_ny;
    logic signed [5:0]   w_vel_inc;

    assign w_key_a = (keycode0 == KEY_A) || (keycode1 == KEY_A);
    assign w_key_d = (keycode0 == KEY_D) || (keycode1 == KEY_D);
    assign w_jump  = (keycode0 == KEY_W) || (keycode1 == KEY_W) ||
                     (keycode0 == KEY_SPACE) || (keycode1 == KEY_SPACE);

    assign w_ny      = $signed({1'b0, r_y}) + $signed({{5{r_vel[5]}}, r_vel});
    assign w_vel_inc = r_vel + VEL_GRAV;

    // Next-state: walking/clamping, jump arming and the vertical state machine
    always_comb begin
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_vel_next    = r_vel;
        w_state_next  = r_state;
        w_facing_next = r_facing;
        w_armed_next  = r_armed;
        w_x_sum       = $signed({1'b0, r_x});

        // Walking applies in every state; A and D together cancel out
        if (w_key_d && !w_key_a) begin
            w_x_sum       = $signed({1'b0, r_x}) + 11'(STEP_X);
            w_facing_next = 1'b0;
        end else if (w_key_a && !w_key_d) begin
            w_x_sum       = $signed({1'b0, r_x}) - 11'(STEP_X);
            w_facing_next = 1'b1;
        end

        if (w_x_sum < X_LO_S) begin
            w_x_next = X_LO_S[9:0];
        end else if (w_x_sum > X_HI_S) begin
            w_x_next = X_HI_S[9:0];
        end else begin
            w_x_next = w_x_sum[9:0];
        end

        // Releasing the jump key re-arms; take-off below disarms
        if (!w_jump) begin
            w_armed_next = 1'b1;
        end

        case (r_state)
            GROUND: begin
                if (w_jump && r_armed) begin
                    w_vel_next   = VEL_TAKEOFF;
                    w_y_next     = 10'(Y_GROUND - JUMP_V);
                    w_state_next = RISE;
                    w_armed_next = 1'b0;
                end else begin
                    w_y_next = Y_GROUND_S[9:0];
                end
            end
            RISE: begin
                if (w_ny < Y_TOP_S) begin
                    w_y_next     = Y_TOP_S[9:0];
                    w_vel_next   = '0;
                    w_state_next = FALL;
                end else begin
                    w_y_next   = w_ny[9:0];
                    w_vel_next = w_vel_inc;
                    if (!w_vel_inc[5]) begin
                        w_state_next = FALL;
                    end
                end
            end
            FALL: begin
                // Landing tick never takes off, even with an armed jump held
                if (w_ny >= Y_GROUND_S) begin
                    w_y_next     = Y_GROUND_S[9:0];
                    w_vel_next   = '0;
                    w_state_next = GROUND;
                end else begin
                    w_y_next   = w_ny[9:0];
                    w_vel_next = (w_vel_inc > VEL_MAX) ? VEL_MAX : w_vel_inc;
                end
            end
            default: begin
                w_state_next = GROUND;
                w_y_next     = Y_GROUND_S[9:0];
                w_vel_next   = '0;
            end
        endcase
    end

    // Motion state registers, advanced only on the frame tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x      <= 10'(X_START);
            r_y      <= 10'(Y_GROUND);
            r_vel    <= '0;
            r_state  <= GROUND;
            r_facing <= 1'b0;
            r_armed  <= 1'b1;
        end else if (w_tick) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_vel    <= w_vel_next;
            r_state  <= w_state_next;
            r_facing <= w_facing_next;
            r_armed  <= w_armed_next;
        end
    end

    assign KnightX      = r_x;
    assign KnightY      = r_y;
    assign Knight_sizeX = 10'(SIZE_X);
    assign Knight_sizeY = 10'(SIZE_Y);
    assign facing_left  = r_facing;
    assign airborne     = (r_state == RISE) || (r_state == FALL);

endmodule
